cc_engine: RTL and testbench
============================

CC_ENGINE -- requirements
Module: cc_engine

Interface
REQ-001 Parameter ROWS, default 6, board rows (3..8); row 0 is top and row ROWS-1 is bottom.
REQ-002 Parameter COLS, default 6, board columns (3..8).
REQ-003 Parameter CW, default 3, candy colour width; colour 0 means empty.
REQ-004 Parameter SW, default 7, score width.
REQ-005 clk  in  1  the single clock; one clock; reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid_1  in  1  board-load strobe.
REQ-008 in_color  in  CW  candy colour, valid with in_valid_1.
REQ-009 in_valid_2  in  1  action strobe.
REQ-010 in_pos  in  6  action position {row[2:0], col[2:0]}, valid with in_valid_2.
REQ-011 in_action  in  2  swap direction (0 up, 1 down, 2 left, 3 right), valid with in_valid_2.
REQ-012 in_last  in  1  marks the final action of a game, valid with in_valid_2.
REQ-013 in_ready  out  1  high when an action (or a load beat) is accepted this cycle.
REQ-014 out_valid  out  1  final-score strobe.
REQ-015 out_score  out  SW  final score; 0 whenever out_valid is 0.

Function
REQ-016 FSM states: IDLE, LOAD, WAIT_ACT, SWAP, DETECT, CLEAR, FALL, DONE.
REQ-017 IDLE->LOAD on the first in_valid_1 beat; LOAD takes exactly ROWS*COLS beats, row-major from (0,0); the score clears to 0 on the first beat.
REQ-018 After the last load beat, LOAD->WAIT_ACT; the loaded board is not resolved at load time.
REQ-019 in_ready is 1 in IDLE, LOAD and WAIT_ACT and 0 in all other states; in_valid_2 while in_ready=0 is ignored.
REQ-020 WAIT_ACT->SWAP on in_valid_2; in_pos, in_action and in_last are captured.
REQ-021 SWAP (1 cycle) exchanges the cell at in_pos with its neighbour in the given direction.
REQ-022 If in_pos is outside the board, or the neighbour is outside the board, the swap is a no-op, but resolution still runs.
REQ-023 A swap that produces no match is kept, not reverted.
REQ-024 DETECT (1 cycle) marks every nonzero cell that belongs to a horizontal or vertical run of 3 or more equal colours; cells in crossing runs are marked once.
REQ-025 If no cell is marked: DETECT->DONE when the captured in_last=1, else DETECT->WAIT_ACT.
REQ-026 If any cell is marked, DETECT->CLEAR.
REQ-027 CLEAR (1 cycle) sets all marked cells to 0 and adds the marked-cell count to the score; the score saturates at 2^SW-1.
REQ-028 FALL, once per cycle, acts on each column that has a 0 cell with a nonzero cell above it: the lowest such 0 cell is found, every cell above it shifts down one row, and the top cell becomes 0.
REQ-029 FALL->DETECT when no column qualifies, which permits cascades.
REQ-030 DONE (1 cycle) drives out_valid=1 with out_score equal to the score, then goes to IDLE; out_valid is never high for two consecutive cycles.
REQ-031 Latency from the accepted last action to out_valid: no more than 8*ROWS*COLS cycles for default parameters (<500 cycles).
REQ-032 in_valid_1 in any state other than IDLE or LOAD is ignored.

Reset
REQ-033 rst=1 at a clock edge forces IDLE, clears the board to 0 and the score to 0, sets out_valid=0, out_score=0 and in_ready=1; this holds from any state, including mid-cascade.
REQ-034 An action in flight when reset is asserted is discarded, and no out_valid follows it.

Verification
REQ-035 Reset sequence: rst held 2 cycles -> out_valid=0, out_score=0, in_ready=1 on the cycle after release.
REQ-036 Single match: rows 0-4 all 0, row5=2,2,3,2,0,0; one action (5,2) right with in_last=1 -> one out_valid pulse with out_score=3.
REQ-037 Cascade: row3=0,0,1,0,0,0; row4=1,1,0,0,0,0; row5=2,2,3,2,0,0; action (5,2) right with in_last=1 -> out_score=6 (3 from the swap match, 3 from the row5=1,1,1 match formed after FALL).
REQ-038 Boundary and variable count: board as in REQ-036; action (5,5) right with in_last=0, then (0,0) up with in_last=1 -> both are no-ops, out_score=0 and out_valid still pulses once.
REQ-039 Saturation and handshake: SW=2, REQ-037 stimulus, in_valid_2 also driven during resolution -> out_score=3; actions presented while in_ready=0 have no effect.
REQ-040 Reset mid-operation: rst asserted during FALL of REQ-037 -> no out_valid, outputs 0; the REQ-036 stimulus replayed afterwards gives out_score=3.

Source files
------------

// File: rtl/cc_engine.sv
// cc_engine: match-3 board engine with swap, detect, clear, gravity cascades and a saturating score
module cc_engine #(
  parameter int ROWS = 6,
  parameter int COLS = 6,
  parameter int CW   = 3,
  parameter int SW   = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_1,
  input  logic [CW-1:0] in_color,
  input  logic          in_valid_2,
  input  logic [5:0]    in_pos,
  input  logic [1:0]    in_action,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [SW-1:0] out_score
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACT, SWAP, DETECT, CLEAR, FALL, DONE} state_t;
  localparam int SMAX = (1 << SW) - 1;
  state_t state_q, state_d;
  logic [CW-1:0] board_q [ROWS][COLS];
  logic [CW-1:0] board_d [ROWS][COLS];
  logic [CW-1:0] fall_b [ROWS][COLS];
  logic mark [ROWS][COLS];
  logic [SW-1:0] score_q, score_d;
  logic [2:0] ld_r_q, ld_r_d, ld_c_q, ld_c_d, wr_r, wr_c;
  logic [5:0] pos_q, pos_d;
  logic [1:0] act_q, act_d;
  logic last_q, last_d;
  logic any_mark, any_fall, swap_ok, seen;
  logic [CW-1:0] pv, nv;
  int mark_cnt, hole, pr, pc, nr, nc, sum;
  always_comb begin
    mark_cnt = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mark[r][c] = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS - 2; c++)
        if (board_q[r][c] != '0 && board_q[r][c] == board_q[r][c+1] && board_q[r][c] == board_q[r][c+2]) begin
          mark[r][c] = 1'b1;
          mark[r][c+1] = 1'b1;
          mark[r][c+2] = 1'b1;
        end
    for (int r = 0; r < ROWS - 2; r++)
      for (int c = 0; c < COLS; c++)
        if (board_q[r][c] != '0 && board_q[r][c] == board_q[r+1][c] && board_q[r][c] == board_q[r+2][c]) begin
          mark[r][c] = 1'b1;
          mark[r+1][c] = 1'b1;
          mark[r+2][c] = 1'b1;
        end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mark_cnt = mark_cnt + (mark[r][c] ? 1 : 0);
    any_mark = mark_cnt != 0;
  end
  always_comb begin
    any_fall = 1'b0;
    hole = -1;
    seen = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      hole = -1;
      seen = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        if (board_q[r][c] == '0 && seen) hole = r;
        if (board_q[r][c] != '0) seen = 1'b1;
      end
      any_fall = any_fall | (hole >= 0);
      fall_b[0][c] = hole >= 0 ? '0 : board_q[0][c];
      for (int r = 1; r < ROWS; r++) fall_b[r][c] = r <= hole ? board_q[r-1][c] : board_q[r][c];
    end
  end
  always_comb begin
    pr = int'(pos_q[5:3]);
    pc = int'(pos_q[2:0]);
    nr = act_q == 2'd0 ? pr - 1 : act_q == 2'd1 ? pr + 1 : pr;
    nc = act_q == 2'd2 ? pc - 1 : act_q == 2'd3 ? pc + 1 : pc;
    swap_ok = pr < ROWS && pc < COLS && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS;
    pv = '0;
    nv = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (r == pr && c == pc) pv = board_q[r][c];
        if (r == nr && c == nc) nv = board_q[r][c];
      end
  end
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    score_d = score_q;
    ld_r_d = ld_r_q;
    ld_c_d = ld_c_q;
    pos_d = pos_q;
    act_d = act_q;
    last_d = last_q;
    wr_r = state_q == IDLE ? 3'd0 : ld_r_q;
    wr_c = state_q == IDLE ? 3'd0 : ld_c_q;
    sum = int'(score_q) + mark_cnt;
    unique case (state_q)
      IDLE, LOAD: if (in_valid_1) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (r == int'(wr_r) && c == int'(wr_c)) board_d[r][c] = in_color;
        ld_c_d = wr_c == 3'(COLS - 1) ? 3'd0 : wr_c + 3'd1;
        ld_r_d = wr_c == 3'(COLS - 1) ? wr_r + 3'd1 : wr_r;
        score_d = state_q == IDLE ? '0 : score_q;
        state_d = wr_r == 3'(ROWS - 1) && wr_c == 3'(COLS - 1) ? WAIT_ACT : LOAD;
      end
      WAIT_ACT: if (in_valid_2) begin
        pos_d = in_pos;
        act_d = in_action;
        last_d = in_last;
        state_d = SWAP;
      end
      SWAP: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (swap_ok && r == pr && c == pc) board_d[r][c] = nv;
            else if (swap_ok && r == nr && c == nc) board_d[r][c] = pv;
        state_d = DETECT;
      end
      DETECT: state_d = any_mark ? CLEAR : last_q ? DONE : WAIT_ACT;
      CLEAR: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (mark[r][c]) board_d[r][c] = '0;
        score_d = SW'(sum > SMAX ? SMAX : sum);
        state_d = FALL;
      end
      FALL: begin
        board_d = fall_b;
        state_d = any_fall ? FALL : DETECT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) board_q[r][c] <= '0;
      score_q <= '0;
      ld_r_q <= '0;
      ld_c_q <= '0;
      pos_q <= '0;
      act_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      score_q <= score_d;
      ld_r_q <= ld_r_d;
      ld_c_q <= ld_c_d;
      pos_q <= pos_d;
      act_q <= act_d;
      last_q <= last_d;
    end
  end
  assign in_ready = state_q == IDLE || state_q == LOAD || state_q == WAIT_ACT;
  assign out_valid = state_q == DONE;
  assign out_score = out_valid ? score_q : '0;
endmodule

// File: tb/tb_cc_engine.sv
// tb_cc_engine: directed scenario bench for cc_engine at default width and with a 2-bit score
module tb_cc_engine;
  logic clk = 1'b0, rst = 1'b1, in_valid_1 = 1'b0, in_valid_2 = 1'b0, in_last = 1'b0;
  logic [2:0] in_color = '0;
  logic [5:0] in_pos = '0;
  logic [1:0] in_action = '0;
  logic in_ready, out_valid, rdy_s, ov_s;
  logic [6:0] out_score;
  logic [1:0] sc_s;
  int pass_cnt = 0, total = 0;
  int pulses, sc, sc_sat, bad;
  logic [2:0] brd [6][6];
  always #5 clk = ~clk;
  cc_engine u_dut (.clk(clk), .rst(rst), .in_valid_1(in_valid_1), .in_color(in_color),
    .in_valid_2(in_valid_2), .in_pos(in_pos), .in_action(in_action), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_score(out_score));
  cc_engine #(.SW(2)) u_sat (.clk(clk), .rst(rst), .in_valid_1(in_valid_1), .in_color(in_color),
    .in_valid_2(in_valid_2), .in_pos(in_pos), .in_action(in_action), .in_last(in_last),
    .in_ready(rdy_s), .out_valid(ov_s), .out_score(sc_s));
  task step;
    @(posedge clk);
    #1;
  endtask
  task base_brd;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) brd[r][c] = 3'd0;
    brd[5][0] = 3'd2;
    brd[5][1] = 3'd2;
    brd[5][2] = 3'd3;
    brd[5][3] = 3'd2;
  endtask
  task cascade_brd;
    base_brd();
    brd[3][2] = 3'd1;
    brd[4][0] = 3'd1;
    brd[4][1] = 3'd1;
  endtask
  task load_board;
    for (int i = 0; i < 36; i++) begin
      in_valid_1 = 1'b1;
      in_color = brd[i / 6][i % 6];
      step();
    end
    in_valid_1 = 1'b0;
  endtask
  task act(input logic [2:0] r, input logic [2:0] c, input logic [1:0] a, input logic l);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) $display("FAIL act_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    in_valid_2 = 1'b1;
    in_pos = {r, c};
    in_action = a;
    in_last = l;
    step();
    in_valid_2 = 1'b0;
  endtask
  task collect(input int cycles, input logic hold);
    logic prev;
    prev = 1'b0;
    pulses = 0;
    sc = 0;
    sc_sat = 0;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      in_valid_2 = hold;
      if (out_valid) begin
        pulses++;
        sc = int'(out_score);
        sc_sat = int'(sc_s);
        if (prev) bad++;
      end else if (out_score != 0) bad++;
      prev = out_valid;
      step();
    end
    in_valid_2 = 1'b0;
  endtask
  task test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: out_valid=%b required 0", out_valid);
    else pass_cnt++;
    total++;
    if (out_score !== 7'd0) $display("FAIL reset_score: out_score=%0d required 0", out_score);
    else pass_cnt++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
  endtask
  task test_single;
    base_brd();
    load_board();
    act(3'd5, 3'd2, 2'd3, 1'b1);
    total++;
    if (in_ready !== 1'b0) $display("FAIL single_busy: in_ready=%b required 0", in_ready);
    else pass_cnt++;
    collect(600, 1'b0);
    total++;
    if (pulses !== 1) $display("FAIL single_pulses: got %0d required 1", pulses);
    else pass_cnt++;
    total++;
    if (sc !== 3) $display("FAIL single_score: got %0d required 3", sc);
    else pass_cnt++;
    total++;
    if (bad !== 0) $display("FAIL single_idle_out: got %0d bad cycles required 0", bad);
    else pass_cnt++;
  endtask
  task test_cascade;
    cascade_brd();
    load_board();
    act(3'd5, 3'd2, 2'd3, 1'b1);
    collect(600, 1'b0);
    total++;
    if (pulses !== 1) $display("FAIL cascade_pulses: got %0d required 1", pulses);
    else pass_cnt++;
    total++;
    if (sc !== 6) $display("FAIL cascade_score: got %0d required 6", sc);
    else pass_cnt++;
  endtask
  task test_boundary;
    base_brd();
    load_board();
    act(3'd5, 3'd5, 2'd3, 1'b0);
    collect(20, 1'b0);
    total++;
    if (pulses !== 0) $display("FAIL boundary_early: got %0d pulses required 0", pulses);
    else pass_cnt++;
    act(3'd0, 3'd0, 2'd0, 1'b1);
    collect(600, 1'b0);
    total++;
    if (pulses !== 1) $display("FAIL boundary_pulses: got %0d required 1", pulses);
    else pass_cnt++;
    total++;
    if (sc !== 0) $display("FAIL boundary_score: got %0d required 0", sc);
    else pass_cnt++;
  endtask
  task test_saturation;
    cascade_brd();
    load_board();
    act(3'd5, 3'd2, 2'd3, 1'b1);
    in_pos = {3'd5, 3'd3};
    in_action = 2'd2;
    in_last = 1'b0;
    collect(600, 1'b1);
    total++;
    if (pulses !== 1) $display("FAIL sat_pulses: got %0d required 1", pulses);
    else pass_cnt++;
    total++;
    if (sc_sat !== 3) $display("FAIL sat_score: got %0d required 3", sc_sat);
    else pass_cnt++;
    total++;
    if (sc !== 6) $display("FAIL sat_wide_score: got %0d required 6", sc);
    else pass_cnt++;
    total++;
    if (bad !== 0) $display("FAIL sat_idle_out: got %0d bad cycles required 0", bad);
    else pass_cnt++;
  endtask
  task test_reset_mid;
    cascade_brd();
    load_board();
    act(3'd5, 3'd2, 2'd3, 1'b1);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    collect(200, 1'b0);
    total++;
    if (pulses !== 0) $display("FAIL rstmid_pulses: got %0d required 0", pulses);
    else pass_cnt++;
    total++;
    if (out_score !== 7'd0) $display("FAIL rstmid_score: out_score=%0d required 0", out_score);
    else pass_cnt++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_ready: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    test_single();
  endtask
  initial begin
    test_reset();
    test_single();
    test_cascade();
    test_boundary();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
